// File: rtl/uart_echo_buffer.sv
// UART echo engine: buffers received frames in a FIFO and replays them to the transmitter
// (echo / uppercase echo / sink), with saturating error and overflow counters and a marker LED.
module uart_echo_buffer #(
   parameter int                DATA_W      = 8,
   parameter int                DEPTH       = 16,
   parameter int                CNT_W       = 16,
   parameter int                TIMEOUT     = 2000,
   parameter logic [DATA_W-1:0] TOGGLE_CHAR = DATA_W'('h0A)
) (
   input  logic                       sysclk,
   input  logic                       reset_n,
   input  logic [1:0]                 mode_i,
   input  logic                       rx_end_i,
   input  logic                       rx_err_i,
   input  logic [DATA_W-1:0]          rx_data_i,
   input  logic                       tx_end_i,
   output logic                       tx_start_o,
   output logic [DATA_W-1:0]          tx_data_o,
   output logic [$clog2(DEPTH):0]     fifo_level_o,
   output logic                       fifo_full_o,
   output logic                       fifo_empty_o,
   output logic [CNT_W-1:0]           err_cnt_o,
   output logic [CNT_W-1:0]           ovf_cnt_o,
   output logic                       tx_timeout_o,
   output logic                       led_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   // Handshakes: rx_end_i is a one-cycle "valid" with no ready (a frame is either pushed or
   // counted as overflow); tx_start_o is a one-cycle request and tx_end_i the completion,
   // honoured only while waiting for it.
   typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]       level_q, level_d;
   logic [TW-1:0]       wait_cnt_q;
   logic [DATA_W-1:0]   push_data;
   logic                rx_good, push_req, push, pop;

   always_comb begin
      push_data = rx_data_i;
      if (mode_i == 2'd1 && rx_data_i[7:0] >= 8'h61 && rx_data_i[7:0] <= 8'h7A)
         push_data[7:0] = rx_data_i[7:0] - 8'h20;
   end

   assign rx_good  = rx_end_i & ~rx_err_i;
   assign push_req = rx_good & (mode_i != 2'd2);
   assign pop      = (state_q == S_IDLE) && (level_q != '0);
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign push     = push_req && ((level_q != LW'(DEPTH)) || pop);
   assign level_d  = level_q + LW'(push) - LW'(pop);

   always_ff @(posedge sysclk) begin
      if (push)
         mem[wr_ptr_q] <= push_data;
   end

   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         fifo_full_o  <= 1'b0;
         fifo_empty_o <= 1'b0;
         tx_data_o    <= '0;
      end else begin
         if (push)
            wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop) begin
            rd_ptr_q  <= rd_ptr_q + 1'b1;
            tx_data_o <= mem[rd_ptr_q];
         end
         level_q      <= level_d;
         fifo_full_o  <= (level_d == LW'(DEPTH));
         fifo_empty_o <= (level_d == '0);
      end
   end

   assign fifo_level_o = level_q;

   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         err_cnt_o <= '0;
         ovf_cnt_o <= '0;
         led_o     <= 1'b0;
      end else begin
         if (rx_end_i && rx_err_i && err_cnt_o != '1)
            err_cnt_o <= err_cnt_o + 1'b1;
         if (push_req && !push && ovf_cnt_o != '1)
            ovf_cnt_o <= ovf_cnt_o + 1'b1;
         if (rx_good && rx_data_i == TOGGLE_CHAR)
            led_o <= ~led_o;
      end
   end

   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= (state_q == S_WAIT) ? wait_cnt_q + 1'b1 : '0;
      end
   end

   // wait_cnt_q is 0 in the first WAIT cycle, so the timeout fires TIMEOUT cycles after entry.
   always_comb begin
      state_d      = state_q;
      tx_timeout_o = 1'b0;
      case (state_q)
         S_IDLE: if (level_q != '0) state_d = S_SEND;
         S_SEND: state_d = S_WAIT;
         S_WAIT: begin
            if (tx_end_i) begin
               state_d = S_IDLE;
            end else if (TIMEOUT != 0 && wait_cnt_q == TW'(TIMEOUT)) begin
               tx_timeout_o = 1'b1;
               state_d      = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign tx_start_o = (state_q == S_SEND);

endmodule

// File: tb/tb_uart_echo_buffer.sv
// Directed bench for uart_echo_buffer: echo, uppercase, overflow, errors/LED, timeout, reset.
module tb_uart_echo_buffer;

   localparam int DATA_W  = 8;
   localparam int DEPTH   = 16;
   localparam int CNT_W   = 16;
   localparam int TIMEOUT = 50;

   logic                 sysclk = 1'b0;
   logic                 reset_n = 1'b1;
   logic [1:0]           mode_i = 2'd0;
   logic                 rx_end_i = 1'b0;
   logic                 rx_err_i = 1'b0;
   logic [DATA_W-1:0]    rx_data_i = '0;
   logic                 tx_end_i = 1'b0;
   logic                 tx_start_o;
   logic [DATA_W-1:0]    tx_data_o;
   logic [$clog2(DEPTH):0] fifo_level_o;
   logic                 fifo_full_o;
   logic                 fifo_empty_o;
   logic [CNT_W-1:0]     err_cnt_o;
   logic [CNT_W-1:0]     ovf_cnt_o;
   logic                 tx_timeout_o;
   logic                 led_o;

   uart_echo_buffer #(
      .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .TOGGLE_CHAR(8'h0A)
   ) dut (
      .sysclk(sysclk), .reset_n(reset_n), .mode_i(mode_i),
      .rx_end_i(rx_end_i), .rx_err_i(rx_err_i), .rx_data_i(rx_data_i),
      .tx_end_i(tx_end_i), .tx_start_o(tx_start_o), .tx_data_o(tx_data_o),
      .fifo_level_o(fifo_level_o), .fifo_full_o(fifo_full_o), .fifo_empty_o(fifo_empty_o),
      .err_cnt_o(err_cnt_o), .ovf_cnt_o(ovf_cnt_o), .tx_timeout_o(tx_timeout_o), .led_o(led_o)
   );

   // clock / cycle counter
   always #5 sysclk = ~sysclk;
   int cyc = 0;
   always @(posedge sysclk) cyc++;

   int n_cmp = 0;
   int n_bad = 0;

   // transmit monitor: records every start and timeout with its cycle number
   logic [DATA_W-1:0] got_q[$];
   int                start_q[$];
   int                to_q[$];
   logic [DATA_W-1:0] exp_q[$];

   always @(negedge sysclk) begin
      if (tx_start_o) begin
         got_q.push_back(tx_data_o);
         start_q.push_back(cyc);
      end
      if (tx_timeout_o)
         to_q.push_back(cyc);
   end

   // drivers: every task starts and ends 1 time unit after a rising edge
   task automatic tick(input int n);
      repeat (n) @(posedge sysclk);
      #1;
   endtask

   task automatic rx_frame(input logic [DATA_W-1:0] d, input logic err);
      rx_end_i  = 1'b1;
      rx_err_i  = err;
      rx_data_i = d;
      tick(1);
      rx_end_i  = 1'b0;
      rx_err_i  = 1'b0;
   endtask

   task automatic ack();
      tx_end_i = 1'b1;
      tick(1);
      tx_end_i = 1'b0;
   endtask

   task automatic wait_tx(input int n, input int limit);
      int t = 0;
      while (got_q.size() < n && t < limit) begin
         tick(1);
         t++;
      end
      n_cmp++;
      if (got_q.size() < n) begin
         n_bad++;
         $display("FAIL wait_tx: got %0d starts, need %0d within %0d cycles", got_q.size(), n, limit);
      end
   endtask

   task automatic clear_mon();
      got_q.delete();
      start_q.delete();
      to_q.delete();
      exp_q.delete();
   endtask

   task automatic test_reset();
      #1 reset_n = 1'b0;
      #2;
      n_cmp++;
      if ({tx_start_o, tx_data_o, fifo_level_o, fifo_full_o, fifo_empty_o, tx_timeout_o, led_o} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: start=%b data=%h lvl=%0d full=%b empty=%b to=%b led=%b, need all 0",
                  tx_start_o, tx_data_o, fifo_level_o, fifo_full_o, fifo_empty_o, tx_timeout_o, led_o);
      end
      n_cmp++;
      if (err_cnt_o !== '0 || ovf_cnt_o !== '0) begin
         n_bad++;
         $display("FAIL reset_counters: err=%0d ovf=%0d, need 0/0", err_cnt_o, ovf_cnt_o);
      end
      tick(3);
      reset_n = 1'b1;
      tick(1);
      n_cmp++;
      if (fifo_empty_o !== 1'b1 || fifo_level_o !== '0) begin
         n_bad++;
         $display("FAIL reset_empty: empty=%b lvl=%0d, need 1/0", fifo_empty_o, fifo_level_o);
      end
   endtask

   task automatic test_echo();
      int k;
      clear_mon();
      mode_i = 2'd0;
      k = cyc;
      rx_frame(8'h41, 1'b0);
      wait_tx(1, 10);
      if (got_q.size() >= 1) begin
         n_cmp++;
         if (got_q[0] !== 8'h41) begin
            n_bad++;
            $display("FAIL echo_data: got %h, need 41", got_q[0]);
         end
         n_cmp++;
         if (start_q[0] !== k + 2) begin
            n_bad++;
            $display("FAIL echo_latency: start at %0d, need %0d", start_q[0], k + 2);
         end
      end
      ack();
      tick(2);
      n_cmp++;
      if (fifo_level_o !== '0 || fifo_empty_o !== 1'b1) begin
         n_bad++;
         $display("FAIL echo_level: lvl=%0d empty=%b, need 0/1", fifo_level_o, fifo_empty_o);
      end
   endtask

   task automatic test_upper();
      logic [DATA_W-1:0] din [5];
      din = '{8'h61, 8'h7A, 8'h5B, 8'h60, 8'h7B};
      clear_mon();
      exp_q = '{8'h41, 8'h5A, 8'h5B, 8'h60, 8'h7B};
      mode_i = 2'd1;
      for (int i = 0; i < 5; i++) rx_frame(din[i], 1'b0);
      mode_i = 2'd0;
      for (int i = 0; i < 5; i++) begin
         wait_tx(i + 1, 20);
         ack();
      end
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            n_bad++;
            $display("FAIL upper_%0d: got %h, need %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
         end
      end
   endtask

   task automatic test_overflow();
      clear_mon();
      mode_i = 2'd0;
      for (int i = 0; i < 18; i++) rx_frame(8'h10 + 8'(i), 1'b0);
      for (int i = 0; i < 17; i++) exp_q.push_back(8'h10 + 8'(i));
      tick(2);
      n_cmp++;
      if (fifo_level_o !== 5'd16 || fifo_full_o !== 1'b1) begin
         n_bad++;
         $display("FAIL ovf_full: lvl=%0d full=%b, need 16/1", fifo_level_o, fifo_full_o);
      end
      n_cmp++;
      if (ovf_cnt_o !== 16'd1) begin
         n_bad++;
         $display("FAIL ovf_count: got %0d, need 1", ovf_cnt_o);
      end
      n_cmp++;
      if (got_q.size() !== 1) begin
         n_bad++;
         $display("FAIL ovf_inflight: %0d starts, need 1", got_q.size());
      end
      for (int i = 0; i < 17; i++) begin
         wait_tx(i + 1, 20);
         ack();
      end
      for (int i = 0; i < 17; i++) begin
         n_cmp++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            n_bad++;
            $display("FAIL ovf_order_%0d: got %h, need %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
         end
      end
      tick(3);
      n_cmp++;
      if (fifo_level_o !== '0 || fifo_empty_o !== 1'b1 || got_q.size() !== 17) begin
         n_bad++;
         $display("FAIL ovf_drain: lvl=%0d empty=%b starts=%0d, need 0/1/17", fifo_level_o, fifo_empty_o, got_q.size());
      end
   endtask

   task automatic test_err_led();
      clear_mon();
      mode_i = 2'd0;
      for (int i = 0; i < 3; i++) rx_frame(8'h0A, 1'b1);
      rx_frame(8'h0A, 1'b0);
      n_cmp++;
      if (err_cnt_o !== 16'd3 || led_o !== 1'b1) begin
         n_bad++;
         $display("FAIL err_led: err=%0d led=%b, need 3/1", err_cnt_o, led_o);
      end
      wait_tx(1, 10);
      ack();
      n_cmp++;
      if (got_q.size() !== 1 || got_q[0] !== 8'h0A) begin
         n_bad++;
         $display("FAIL err_echo: starts=%0d, need one start of 0a", got_q.size());
      end
      mode_i = 2'd2;
      rx_frame(8'h0A, 1'b0);
      tick(10);
      mode_i = 2'd0;
      n_cmp++;
      if (led_o !== 1'b0 || got_q.size() !== 1 || fifo_level_o !== '0) begin
         n_bad++;
         $display("FAIL sink_led: led=%b starts=%0d lvl=%0d, need 0/1/0", led_o, got_q.size(), fifo_level_o);
      end
      n_cmp++;
      if (err_cnt_o !== 16'd3 || ovf_cnt_o !== 16'd1) begin
         n_bad++;
         $display("FAIL sink_counters: err=%0d ovf=%0d, need 3/1", err_cnt_o, ovf_cnt_o);
      end
   endtask

   task automatic test_timeout();
      int s;
      clear_mon();
      mode_i = 2'd0;
      rx_frame(8'h55, 1'b0);
      rx_frame(8'h66, 1'b0);
      wait_tx(2, 120);
      if (got_q.size() >= 2) begin
         s = start_q[0];
         n_cmp++;
         if (to_q.size() !== 1 || to_q[0] !== s + 51) begin
            n_bad++;
            $display("FAIL timeout_pulse: %0d pulses, first at %0d, need 1 at %0d",
                     to_q.size(), (to_q.size() > 0) ? to_q[0] : -1, s + 51);
         end
         n_cmp++;
         if (start_q[1] !== s + 53 || got_q[1] !== 8'h66) begin
            n_bad++;
            $display("FAIL timeout_next: start %0d data %h, need %0d data 66", start_q[1], got_q[1], s + 53);
         end
      end
      ack();
      tick(3);
      n_cmp++;
      if (fifo_level_o !== '0 || to_q.size() !== 1) begin
         n_bad++;
         $display("FAIL timeout_after: lvl=%0d pulses=%0d, need 0/1", fifo_level_o, to_q.size());
      end
   endtask

   task automatic test_reset_wait();
      clear_mon();
      mode_i = 2'd0;
      for (int i = 0; i < 4; i++) rx_frame(8'h31 + 8'(i), 1'b0);
      wait_tx(1, 10);
      tick(2);
      n_cmp++;
      if (fifo_level_o !== 5'd3) begin
         n_bad++;
         $display("FAIL rstw_pre: lvl=%0d, need 3", fifo_level_o);
      end
      reset_n = 1'b0;
      #2;
      n_cmp++;
      if ({tx_start_o, tx_data_o, fifo_level_o, fifo_full_o, fifo_empty_o, tx_timeout_o, led_o} !== '0 ||
          err_cnt_o !== '0 || ovf_cnt_o !== '0) begin
         n_bad++;
         $display("FAIL rstw_outputs: data=%h lvl=%0d err=%0d ovf=%0d empty=%b, need all 0",
                  tx_data_o, fifo_level_o, err_cnt_o, ovf_cnt_o, fifo_empty_o);
      end
      tick(2);
      reset_n = 1'b1;
      got_q.delete();
      tick(20);
      n_cmp++;
      if (got_q.size() !== 0 || fifo_level_o !== '0 || fifo_empty_o !== 1'b1) begin
         n_bad++;
         $display("FAIL rstw_after: starts=%0d lvl=%0d empty=%b, need 0/0/1", got_q.size(), fifo_level_o, fifo_empty_o);
      end
   endtask

   initial begin
      test_reset();
      test_echo();
      test_upper();
      test_overflow();
      test_err_led();
      test_timeout();
      test_reset_wait();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
